// File: rtl/apb_pkg.sv
// apb_pkg: default APB widths, sequencer FSM state enum and request record shared by the sequencer and its queue
package apb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, RESP} state_t;
  typedef struct packed {
    logic write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [DATA_W_DEF/8-1:0] strb;
  } req_t;
endpackage

// File: rtl/apb_req_fifo.sv
// apb_req_fifo: synchronous DEPTH-entry queue (clk, rst, push/din in, pop, dout/full/empty/level out)
module apb_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/apb_req_sequencer.sv
// apb_req_sequencer: queues requests (req_*), issues them one at a time as 2-cycle PTX pulses (PTX/WRITE/ADDR/WDATA/STRB, PRDATA back) and returns completions (rsp_*), with queue occupancy on level
module apb_req_sequencer
  import apb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int SW = DATA_W/8,
  localparam int RW = 1 + ADDR_W + DATA_W + SW,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SW-1:0]     req_strb,
  output logic              PTX,
  output logic              WRITE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WDATA,
  output logic [SW-1:0]     STRB,
  input  logic [DATA_W-1:0] PRDATA,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [LW-1:0]     level
);
  state_t state, state_nx;
  logic rdy_en, empty, full, load;
  logic [RW-1:0] head;
  logic h_write;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [SW-1:0] h_strb;
  apb_req_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk(PCLK),
    .rst(!PRESET),
    .push(req_valid && req_ready),
    .pop(load),
    .din({req_write, req_addr, req_wdata, req_strb}),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  assign req_ready = PRESET && rdy_en && !full;
  always_comb begin
    load = !empty && (state == IDLE || (state == RESP && rsp_ready));
    state_nx = load ? SETUP :
               state == SETUP ? ACCESS :
               state == ACCESS ? CAPTURE :
               state == CAPTURE ? RESP :
               (state == RESP && rsp_ready) ? IDLE : state;
    PTX = state == SETUP || state == ACCESS;
    WRITE = PTX && h_write;
    ADDR = PTX ? h_addr : '0;
    WDATA = WRITE ? h_wdata : '0;
    STRB = WRITE ? h_strb : '0;
    rsp_valid = state == RESP;
    rsp_write = rsp_valid && h_write;
  end
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state <= IDLE;
      rdy_en <= 1'b0;
      {h_write, h_addr, h_wdata, h_strb} <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      rdy_en <= 1'b1;
      if (load) {h_write, h_addr, h_wdata, h_strb} <= head;
      if (state == CAPTURE) rsp_rdata <= h_write ? '0 : PRDATA;
    end
  end
endmodule

// File: tb/tb_apb_req_sequencer.sv
// tb_apb_req_sequencer: directed table, corner sequences and random traffic against a queue/memory reference model
module tb_apb_req_sequencer;
  import apb_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {req_t r; logic [31:0] rd;} vec_t;
  logic PCLK = 0, PRESET = 0, req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [7:0] req_addr = 0;
  logic [31:0] req_wdata = 0, PRDATA = 0;
  logic [3:0] req_strb = 0;
  logic req_ready, PTX, WRITE, rsp_valid, rsp_write;
  logic [7:0] ADDR;
  logic [31:0] WDATA, rsp_rdata;
  logic [3:0] STRB;
  logic [2:0] level;
  logic [31:0] apb_mem [256];
  logic [31:0] ref_mem [256];
  bit mem_init = 0;
  int acc_cnt = 0;
  req_t exp_q [$];
  int starts [$];
  int pushed = 0, issued = 0, done_n = 0, ptx_len = 0, cyc = 0, n_chk = 0, n_fail = 0;
  bit rst_edge = 0;
  vec_t tbl [9];
  always #5 PCLK = ~PCLK;
  apb_req_sequencer #(.DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .PTX(PTX), .WRITE(WRITE), .ADDR(ADDR), .WDATA(WDATA), .STRB(STRB), .PRDATA(PRDATA),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .level(level)
  );
  function automatic logic [31:0] init_val(input int i);
    return i == 8'h0A ? 32'h11223344 : i == 8'h0F ? 32'hCAFEF00D : 32'h0;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction
  function automatic req_t mk(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.write = w; r.addr = a; r.wdata = d; r.strb = s;
    return r;
  endfunction
  // APB completer: commits writes / latches read data on the second PTX cycle,
  // and presents that read data only during the following cycle
  always @(posedge PCLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) apb_mem[i] = init_val(i);
      mem_init = 1;
    end
    if (!PRESET || !PTX) acc_cnt = 0;
    else acc_cnt++;
    if (acc_cnt == 2) begin
      if (WRITE) apb_mem[ADDR] = merge(apb_mem[ADDR], WDATA, STRB);
      else PRDATA <= apb_mem[ADDR];
    end else PRDATA <= $urandom;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic monitor();
    req_t h;
    if (rst_edge) begin
      chk("rst_ptx", 64'(PTX), 0);
      chk("rst_write", 64'(WRITE), 0);
      chk("rst_addr", 64'(ADDR), 0);
      chk("rst_wdata", 64'(WDATA), 0);
      chk("rst_strb", 64'(STRB), 0);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_rsp_write", 64'(rsp_write), 0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
      chk("rst_level", 64'(level), 0);
      if (!PRESET) chk("rst_req_ready", 64'(req_ready), 0);
      exp_q.delete();
      pushed = 0; issued = 0; ptx_len = 0;
    end else begin
      if (PTX) begin
        if (ptx_len == 0) begin issued++; starts.push_back(cyc); end
        ptx_len++;
        if (exp_q.size() == 0) chk("ptx_unexpected", 64'(PTX), 0);
        else begin
          h = exp_q[0];
          chk("ptx_write", 64'(WRITE), 64'(h.write));
          chk("ptx_addr", 64'(ADDR), 64'(h.addr));
          chk("ptx_wdata", 64'(WDATA), h.write ? 64'(h.wdata) : 0);
          chk("ptx_strb", 64'(STRB), h.write ? 64'(h.strb) : 0);
        end
      end else begin
        if (ptx_len != 0) chk("ptx_len", 64'(ptx_len), 2);
        ptx_len = 0;
      end
      chk("level", 64'(level), 64'(pushed - issued));
      chk("req_ready", 64'(req_ready), 64'((pushed - issued) < DEPTH));
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 0);
        else begin
          h = exp_q[0];
          chk("rsp_write", 64'(rsp_write), 64'(h.write));
          chk("rsp_rdata", 64'(rsp_rdata), h.write ? 0 : 64'(ref_mem[h.addr]));
        end
      end
    end
  endtask
  task automatic tick();
    req_t h;
    #1;
    if (PRESET && rsp_valid && rsp_ready && exp_q.size() > 0) begin
      h = exp_q.pop_front();
      if (h.write) ref_mem[h.addr] = merge(ref_mem[h.addr], h.wdata, h.strb);
      done_n++;
    end
    if (PRESET && req_valid && req_ready) begin
      exp_q.push_back(mk(req_write, req_addr, req_wdata, req_strb));
      pushed++;
    end
    rst_edge = !PRESET;
    @(negedge PCLK);
    cyc++;
    monitor();
  endtask
  task automatic offer(input req_t r);
    req_valid = 1; req_write = r.write; req_addr = r.addr; req_wdata = r.wdata; req_strb = r.strb;
  endtask
  task automatic do_one(input string nm, input req_t r, input logic [31:0] rd);
    int k;
    int s0 = starts.size();
    rsp_ready = 1;
    offer(r);
    tick();
    req_valid = 0;
    for (k = 0; k < 20 && !rsp_valid; k++) tick();
    chk({nm, "_rsp_seen"}, 64'(rsp_valid), 1);
    chk({nm, "_pulses"}, 64'(starts.size() - s0), 1);
    if (rsp_valid) begin
      chk({nm, "_rsp_write"}, 64'(rsp_write), 64'(r.write));
      chk({nm, "_rsp_rdata"}, 64'(rsp_rdata), 64'(rd));
    end
    tick();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, s0, d0, p0;
    logic [31:0] last_rd;
    tbl[0] = '{mk(1, 8'h05, 32'h0000ABCD, 4'b0111), 32'h0};
    tbl[1] = '{mk(0, 8'h05, 32'hFFFFFFFF, 4'b1111), 32'h0000ABCD};
    tbl[2] = '{mk(0, 8'h0F, 32'h0, 4'b0000), 32'hCAFEF00D};
    tbl[3] = '{mk(1, 8'h0F, 32'hDEADBEEF, 4'b1100), 32'h0};
    tbl[4] = '{mk(0, 8'h0F, 32'h0, 4'b0000), 32'hDEADF00D};
    tbl[5] = '{mk(1, 8'h30, 32'h12345678, 4'b0001), 32'h0};
    tbl[6] = '{mk(0, 8'h30, 32'h0, 4'b0000), 32'h00000078};
    tbl[7] = '{mk(1, 8'h30, 32'hAABBCCDD, 4'b0000), 32'h0};
    tbl[8] = '{mk(0, 8'h30, 32'h0, 4'b1010), 32'h00000078};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(negedge PCLK);
    for (int i = 0; i < 3; i++) begin req_valid = 1; tick(); end
    req_valid = 0;
    PRESET = 1;
    #1 chk("release_req_ready_low", 64'(req_ready), 0);
    tick();
    chk("release_req_ready_high", 64'(req_ready), 1);
    for (int i = 0; i < 9; i++) do_one($sformatf("tbl%0d", i), tbl[i].r, tbl[i].rd);
    // back-to-back write then read of the same address
    rsp_ready = 1;
    s0 = starts.size(); d0 = done_n; last_rd = 0;
    offer(mk(1, 8'h0A, 32'h33003300, 4'b1010));
    tick();
    offer(mk(0, 8'h0A, 32'h0, 4'b0000));
    tick();
    req_valid = 0;
    for (k = 0; k < 30 && done_n - d0 < 2; k++) begin
      if (rsp_valid && !rsp_write) last_rd = rsp_rdata;
      tick();
    end
    chk("b2b_done", 64'(done_n - d0), 2);
    chk("b2b_pulses", 64'(starts.size() - s0), 2);
    if (starts.size() - s0 == 2) chk("b2b_spacing", 64'(starts[s0+1] - starts[s0]), 4);
    chk("b2b_rdata", 64'(last_rd), 32'h33223344);
    // fill the queue behind a stalled response
    rsp_ready = 0;
    d0 = done_n; p0 = pushed;
    for (int i = 0; i < 5; i++) begin
      offer(mk(1, 8'h40 + 8'(i), 32'h11111111 * (i + 1), 4'b1111));
      tick();
    end
    chk("full_pushes", 64'(pushed - p0), 5);
    chk("full_req_ready", 64'(req_ready), 0);
    chk("full_level", 64'(level), 4);
    offer(mk(0, 8'h40, 32'h0, 4'b0000));
    for (int i = 0; i < 3; i++) tick();
    chk("full_no_push", 64'(pushed - p0), 5);
    chk("stall_rsp_valid", 64'(rsp_valid), 1);
    req_valid = 0;
    rsp_ready = 1;
    for (k = 0; k < 60 && done_n - d0 < 5; k++) tick();
    chk("full_drained", 64'(done_n - d0), 5);
    tick();
    chk("full_level_empty", 64'(level), 0);
    do_one("rd_44", mk(0, 8'h44, 32'h0, 4'b0000), 32'h55555555);
    // reset during ACCESS of a write
    rsp_ready = 1;
    offer(mk(1, 8'h0F, 32'h01020304, 4'b1111));
    tick();
    offer(mk(0, 8'h05, 32'h0, 4'b0000));
    tick();
    req_valid = 0;
    for (k = 0; k < 10 && ptx_len != 2; k++) tick();
    chk("mid_access_reached", 64'(ptx_len), 2);
    PRESET = 0;
    tick();
    chk("mid_rst_ptx", 64'(PTX), 0);
    chk("mid_rst_level", 64'(level), 0);
    PRESET = 1;
    #1 chk("mid_rel_req_ready_low", 64'(req_ready), 0);
    tick();
    chk("mid_rel_req_ready_high", 64'(req_ready), 1);
    d0 = done_n;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_no_rsp", 64'(done_n - d0), 0);
    do_one("post_rst_rd0F", mk(0, 8'h0F, 32'h0, 4'b0000), 32'hDEADF00D);
    do_one("post_rst_rd05", mk(0, 8'h05, 32'h0, 4'b0000), 32'h0000ABCD);
    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_addr = {5'b01100, 3'($urandom)};
      req_wdata = $urandom;
      req_strb = 4'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    req_valid = 0;
    rsp_ready = 1;
    for (k = 0; k < 200 && (exp_q.size() != 0 || PTX); k++) tick();
    chk("random_drained", 64'(exp_q.size()), 0);
    chk("random_level", 64'(level), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
